// File: rtl/conv_pkg.sv
// Shared types for the convolution tile path: pixel/tile geometry and loader FSM states.
package conv_pkg;

    localparam int PX_W     = 4;
    localparam int TILE_DIM = 4;
    localparam int TILE_PX  = TILE_DIM * TILE_DIM;
    localparam int IDX_W    = $clog2(TILE_PX);
    localparam int ROW_W    = $clog2(TILE_DIM);

    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][PX_W-1:0] tile_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/pixel_tile_loader.sv
// Assembles a row-major pixel stream into a 4x4 tile and delivers it with a one-cycle load_enable.
// Delivery one edge after the 16th pixel if downstream is free; px_ready drops while a full tile waits for tile_done.
module pixel_tile_loader
    import conv_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        clear,
    input  logic                                        px_valid,
    input  logic [PX_W-1:0]                             px_data,
    output logic                                        px_ready,
    input  logic                                        tile_done,
    output logic                                        load_enable,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][PX_W-1:0] buffer_pixels,
    output logic [7:0]                                  tile_count
);

    loader_state_t    state;
    tile_t            fill;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             deliver;

    assign px_ready = (state == FILL);

    // clear wins over a delivery that would otherwise happen this cycle
    assign deliver = (state == FULL) && !clear && (!busy || tile_done);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= FILL;
            fill          <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            load_enable   <= 1'b0;
            buffer_pixels <= '0;
            tile_count    <= '0;
        end else begin
            load_enable <= 1'b0;

            if (deliver) begin
                busy <= 1'b1;
            end else if (tile_done) begin
                busy <= 1'b0;
            end

            if (clear) begin
                state <= FILL;
                idx   <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (px_valid) begin
                            fill[idx[IDX_W-1 -: ROW_W]][idx[ROW_W-1:0]] <= px_data;
                            if (idx == IDX_W'(TILE_PX - 1)) begin
                                idx   <= '0;
                                state <= FULL;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (deliver) begin
                            buffer_pixels <= fill;
                            load_enable   <= 1'b1;
                            tile_count    <= tile_count + 8'd1;
                            state         <= FILL;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule
